// File: rtl/seg_display_mux.sv
// Time-multiplexed 7-segment driver: per-digit slot scan, frame-latched shadow, LZ blanking, PWM dimming, blink.
// Outputs lag the internal index/tick state by one cycle; no backpressure, enable=0 freezes the scan and blanks.
module seg_display_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dec_points,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [7:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);

  localparam int TICK_W  = $clog2(REFRESH_DIV);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0]     tick_cnt;
  logic [2:0]            idx;
  logic [3:0]            pwm_cnt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_ph;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0] shadow_dp;

  logic        slot_end, frame_end;
  logic [31:0] val_pad;
  logic [7:0]  dp_pad, mask_pad, lz_mask;
  logic        zero_run;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        lit;
  logic [NUM_DIGITS-1:0] anode_nxt;

  assign slot_end  = enable && (tick_cnt == TICK_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_cnt     <= '0;
      idx          <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      frame_done   <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 4'd1;
      frame_done <= frame_end;
      if (enable) tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;
      if (slot_end) idx <= frame_end ? 3'd0 : idx + 3'd1;
      // Content only changes at the frame boundary so a frame never tears.
      if (frame_end) begin
        shadow_value <= value;
        shadow_dp    <= dec_points;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign val_pad  = 32'(shadow_value);
  assign dp_pad   = 8'(shadow_dp);
  assign mask_pad = 8'(blink_mask);
  assign nib      = val_pad[{idx, 2'b00} +: 4];

  // Zero run from the top digit; a lit DP or a nonzero nibble ends it, digit 0 is never in it.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (zero_run && (val_pad[4*i +: 4] == 4'd0) && !dp_pad[i]) lz_mask[i] = 1'b1;
      else zero_run = 1'b0;
    end
  end

  always_comb begin
    glyph = 7'b1111111;
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  end

  assign lit = enable
            && ((brightness == 4'hF) || (pwm_cnt < brightness))
            && !(lz_blank && lz_mask[idx])
            && !(blink_ph && mask_pad[idx]);

  always_comb begin
    anode_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == 3'(i))) anode_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      anode     <= '1;
      cathode   <= 8'hFF;
      digit_idx <= 3'd0;
    end else begin
      anode     <= anode_nxt;
      cathode   <= lit ? {~dp_pad[idx], glyph} : 8'hFF;
      digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux at 4 digits, 16-cycle slots, 2-frame blink half-period.
module tb_seg_display_mux;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dec_points = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lz_blank = 1'b1;
  logic [3:0]  brightness = 4'hF;
  logic [7:0]  cathode;
  logic [3:0]  anode;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  // Expected per-slot anode and cathode for value 16'h1234, digit 0 first.
  logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] scan_ca [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  // Digit 0 dark in frames 1..6 after reset.
  logic       blink_dark [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  seg_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(16), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .value(value),
    .dec_points(dec_points), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .brightness(brightness), .cathode(cathode), .anode(anode),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    vectors++; if (anode !== 4'b1111) begin miscompares++; $display("FAIL reset_anode: got %b expected 1111", anode); end
    vectors++; if (cathode !== 8'hFF) begin miscompares++; $display("FAIL reset_cathode: got %h expected ff", cathode); end
    vectors++; if (digit_idx !== 3'd0) begin miscompares++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 2) begin
        vectors++; if (anode !== 4'b1110) begin miscompares++; $display("FAIL first_frame_d0_anode: got %b expected 1110", anode); end
        vectors++; if (cathode !== 8'hC0) begin miscompares++; $display("FAIL first_frame_d0_cathode: got %h expected c0", cathode); end
      end
      if (n == 20) begin
        vectors++; if (anode !== 4'b1111) begin miscompares++; $display("FAIL first_frame_d1_anode: got %b expected 1111", anode); end
        vectors++; if (digit_idx !== 3'd1) begin miscompares++; $display("FAIL first_frame_d1_idx: got %0d expected 1", digit_idx); end
      end
    end
  endtask

  task automatic test_scan_order;
    bit ok;
    lz_blank = 1'b0;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL scan_wait: got no frame_done expected one within 200 cycles"); end
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      vectors++; if (anode !== scan_an[j/16]) begin miscompares++; $display("FAIL scan_anode j=%0d: got %b expected %b", j, anode, scan_an[j/16]); end
      vectors++; if (cathode !== scan_ca[j/16]) begin miscompares++; $display("FAIL scan_cathode j=%0d: got %h expected %h", j, cathode, scan_ca[j/16]); end
      vectors++; if (digit_idx !== 3'(j/16)) begin miscompares++; $display("FAIL scan_idx j=%0d: got %0d expected %0d", j, digit_idx, j/16); end
      vectors++; if (frame_done !== (j == 63)) begin miscompares++; $display("FAIL scan_fd j=%0d: got %b expected %b", j, frame_done, (j == 63)); end
    end
  endtask

  task automatic test_shadow;
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      if (j == 10) value = 16'hABCD;
      if (j == 20 || j == 40 || j == 60) begin
        vectors++; if (cathode !== scan_ca[j/16]) begin miscompares++; $display("FAIL shadow_old j=%0d: got %h expected %h", j, cathode, scan_ca[j/16]); end
      end
    end
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      if (j == 5) begin vectors++; if (cathode !== 8'hA1) begin miscompares++; $display("FAIL shadow_new_d0: got %h expected a1", cathode); end end
      if (j == 20) begin vectors++; if (cathode !== 8'hC6) begin miscompares++; $display("FAIL shadow_new_d1: got %h expected c6", cathode); end end
      if (j == 40) begin vectors++; if (cathode !== 8'h83) begin miscompares++; $display("FAIL shadow_new_d2: got %h expected 83", cathode); end end
      if (j == 60) begin vectors++; if (cathode !== 8'h88) begin miscompares++; $display("FAIL shadow_new_d3: got %h expected 88", cathode); end end
    end
  endtask

  task automatic test_leading_zeros;
    bit ok;
    value = 16'h0050; lz_blank = 1'b1; dec_points = 4'b0000;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL lz_wait: got no frame_done expected one within 200 cycles"); end
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      if (j == 5) begin
        vectors++; if (anode !== 4'b1110 || cathode !== 8'hC0) begin miscompares++; $display("FAIL lz_d0: got %b/%h expected 1110/c0", anode, cathode); end
      end
      if (j == 20) begin
        vectors++; if (anode !== 4'b1101 || cathode !== 8'h92) begin miscompares++; $display("FAIL lz_d1: got %b/%h expected 1101/92", anode, cathode); end
      end
      if (j == 40 || j == 60) begin
        vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL lz_blank j=%0d: got %b/%h expected 1111/ff", j, anode, cathode); end
      end
    end
    dec_points = 4'b0100;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL lz_dp_wait: got no frame_done expected one within 200 cycles"); end
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      if (j == 20) begin
        vectors++; if (anode !== 4'b1101 || cathode !== 8'h92) begin miscompares++; $display("FAIL lz_dp_d1: got %b/%h expected 1101/92", anode, cathode); end
      end
      if (j == 40) begin
        vectors++; if (anode !== 4'b1011 || cathode !== 8'h40) begin miscompares++; $display("FAIL lz_dp_d2: got %b/%h expected 1011/40", anode, cathode); end
      end
      if (j == 60) begin
        vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL lz_dp_d3: got %b/%h expected 1111/ff", anode, cathode); end
      end
    end
  endtask

  task automatic test_blink;
    bit ok;
    value = 16'h1234; lz_blank = 1'b0; dec_points = 4'b0000; blink_mask = 4'b0001;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL blink_wait: got no frame_done expected one within 200 cycles"); end
    for (int f = 1; f <= 6; f++) begin
      for (int j = 0; j < 64; j++) begin
        @(negedge clock);
        if (j == 5) begin
          if (blink_dark[f-1]) begin
            vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL blink_dark f=%0d: got %b/%h expected 1111/ff", f, anode, cathode); end
          end else begin
            vectors++; if (anode !== 4'b1110 || cathode !== 8'h99) begin miscompares++; $display("FAIL blink_lit f=%0d: got %b/%h expected 1110/99", f, anode, cathode); end
          end
        end
        if (j == 20) begin
          vectors++; if (anode !== 4'b1101) begin miscompares++; $display("FAIL blink_other f=%0d: got %b expected 1101", f, anode); end
        end
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_brightness;
    int lit_cnt;
    brightness = 4'd4;
    lit_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (anode !== 4'b1111) lit_cnt++;
    end
    vectors++; if (lit_cnt != 16) begin miscompares++; $display("FAIL bright4_64: got %0d lit cycles expected 16", lit_cnt); end
    lit_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (anode !== 4'b1111) lit_cnt++;
    end
    vectors++; if (lit_cnt != 4) begin miscompares++; $display("FAIL bright4_16: got %0d lit cycles expected 4", lit_cnt); end
    brightness = 4'd0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL bright0 c=%0d: got %b/%h expected 1111/ff", c, anode, cathode); end
    end
    brightness = 4'hF;
  endtask

  task automatic test_enable;
    bit ok;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL en_wait: got no frame_done expected one within 200 cycles"); end
    repeat (21) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL en_off: got %b/%h expected 1111/ff", anode, cathode); end
    vectors++; if (digit_idx !== 3'd1) begin miscompares++; $display("FAIL en_off_idx: got %0d expected 1", digit_idx); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      vectors++; if (anode !== 4'b1111 || digit_idx !== 3'd1 || frame_done !== 1'b0) begin
        miscompares++; $display("FAIL en_hold c=%0d: got %b/%0d/%b expected 1111/1/0", c, anode, digit_idx, frame_done);
      end
    end
    enable = 1'b1;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clock);
      if (m == 1) begin
        vectors++; if (anode !== 4'b1101 || cathode !== 8'hB0) begin miscompares++; $display("FAIL en_resume: got %b/%h expected 1101/b0", anode, cathode); end
      end
      if (m == 11) begin
        vectors++; if (digit_idx !== 3'd1) begin miscompares++; $display("FAIL en_tick_held: got %0d expected 1", digit_idx); end
      end
      if (m == 12) begin
        vectors++; if (digit_idx !== 3'd2 || anode !== 4'b1011) begin miscompares++; $display("FAIL en_advance: got %0d/%b expected 2/1011", digit_idx, anode); end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_frame(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_mid_wait: got no frame_done expected one within 200 cycles"); end
    repeat (37) @(negedge clock);
    vectors++; if (digit_idx !== 3'd2) begin miscompares++; $display("FAIL rst_mid_pre: got %0d expected 2", digit_idx); end
    reset_n = 1'b0;
    lz_blank = 1'b1;
    @(negedge clock);
    vectors++; if (anode !== 4'b1111 || cathode !== 8'hFF) begin miscompares++; $display("FAIL rst_mid_out: got %b/%h expected 1111/ff", anode, cathode); end
    vectors++; if (digit_idx !== 3'd0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idx: got %0d/%b expected 0/0", digit_idx, frame_done); end
    reset_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 2) begin
        vectors++; if (anode !== 4'b1110 || cathode !== 8'hC0) begin miscompares++; $display("FAIL rst_mid_shadow0: got %b/%h expected 1110/c0", anode, cathode); end
      end
      if (n == 20) begin
        vectors++; if (anode !== 4'b1111) begin miscompares++; $display("FAIL rst_mid_lz: got %b expected 1111", anode); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_shadow();
    test_leading_zeros();
    test_blink();
    test_brightness();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 1-8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot, minimum 16.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period, minimum 1.
REQ-004 The block SHALL use one clock, `clock`; reset is `reset_n`, synchronous and active-low.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  scan enable; low freezes scanning and blanks the display.
- value  in  4*NUM_DIGITS  nibble per digit; digit 0 is bits [3:0].
- dec_points  in  NUM_DIGITS  decimal point per digit; 1 lights the point.
- blink_mask  in  NUM_DIGITS  1 means the digit blinks.
- lz_blank  in  1  enables leading-zero blanking.
- brightness  in  4  duty level; 0 is off, 15 is full.
- cathode  out  8  active-low segments; [7] is DP, [6:0] is g..a.
- anode  out  NUM_DIGITS  active-low digit select.
- digit_idx  out  3  index of the digit currently driven.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-006 tick_cnt SHALL count 0..REFRESH_DIV-1 while enable=1 and wrap to 0; it SHALL hold while enable=0.
REQ-007 On the cycle tick_cnt=REFRESH_DIV-1, the digit index SHALL advance; it SHALL wrap NUM_DIGITS-1 -> 0.
REQ-008 frame_done SHALL pulse high for one cycle on the clock edge at which the index wraps NUM_DIGITS-1 -> 0.
REQ-009 A shadow copy of value and dec_points SHALL load on that same edge; display content SHALL come only from the shadow, so a frame never tears.
REQ-010 anode, cathode and digit_idx SHALL be registered: one cycle of latency from the internal index/tick state.
REQ-011 anode SHALL have exactly one active (0) bit, at position digit_idx, when the digit is lit; otherwise all bits SHALL be 1.
REQ-012 Glyphs SHALL be standard hex 0-F; examples: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-013 The DP bit SHALL be low when shadow dec_points[idx]=1 and the digit is lit.
REQ-014 Leading-zero blanking (lz_blank=1):
- Digits from NUM_DIGITS-1 downward whose shadow nibble is 0, up to the first nonzero nibble, SHALL be unlit.
- Digit 0 SHALL never be blanked by this rule.
- A lit DP on a digit SHALL stop the zero run at that digit, so that digit stays lit.
REQ-015 A free-running 4-bit pwm_cnt SHALL increment every clock.
- The digit SHALL be lit only when brightness=15 or pwm_cnt<brightness.
- brightness=0 SHALL keep all anodes high.
REQ-016 Blink:
- blink_ph SHALL toggle after every BLINK_FRAMES frame_done pulses.
- While blink_ph=1, digits with blink_mask[idx]=1 SHALL be unlit.
- blink_mask SHALL be sampled live, not shadowed.
REQ-017 enable=0 SHALL force anode to all 1s within one cycle.
- All counters except pwm_cnt SHALL hold.
- Scanning SHALL resume from the held state when enable returns to 1.
REQ-018 When unlit, cathode SHALL be 8'hFF.
REQ-019 digit_idx SHALL be zero-extended when NUM_DIGITS<8.

Reset
REQ-020 While reset_n=0 at a clock edge, the block SHALL set:
- anode all 1s and cathode 8'hFF.
- digit_idx 0 and frame_done 0.
- tick_cnt, pwm_cnt, the blink counter and blink_ph to 0.
- the shadow registers to 0.
REQ-021 Asserting reset mid-slot SHALL take effect at the next edge with no partial-frame shadow load.
- After release, the first frame SHALL display shadow=0 (digit 0 shows "0", others blanked if lz_blank=1).

Verification
REQ-022 The bench SHALL cover these scenarios with NUM_DIGITS=4, REFRESH_DIV=16, BLINK_FRAMES=2:
1. Scan order: value=16'h1234, brightness=15, after first frame_done -> anode cycles 1110, 1101, 1011, 0111, each for 16 clocks; cathodes match glyphs 4, 3, 2, 1; frame_done every 64 clocks.
2. Shadow: change value to 16'hABCD mid-frame -> the current frame still shows 1234; the next frame shows ABCD.
3. Leading zeros: value=16'h0050, lz_blank=1 -> digits 3 and 2 unlit, digits 1 and 0 show 5 and 0. Same with dec_points=4'b0100 -> digit 2 lit showing "0." with DP low.
4. Blink and brightness:
   - blink_mask=4'b0001 -> digit 0 is dark for 2 frames, then lit for 2 frames, repeating.
   - brightness=4 -> anode low 4 of every 16 clocks.
   - brightness=0 -> anode stays 1111.
5. Reset and enable:
   - Assert reset_n=0 mid-slot -> next edge anode=1111, cathode=8'hFF, digit_idx=0.
   - enable=0 -> anode=1111 and tick_cnt holds.
